fx_writeback_unit: RTL and testbench

- Receiving end of the FX unit's result/writeback bundle.
- Buffers GPR writebacks in a small in-order FIFO and drains them one per cycle to the register-file write port under a ready handshake.
- Owns the architected XER status bits (SO, OV, CA) and the CR0 field, updating them from FX status strobes.
- Exposes a forwarding lookup, so dispatch can read values still pending in the FIFO, and a stall back to the FX pipeline.

---
 rtl/fx_pkg.sv | 36 +++
 rtl/fx_writeback_unit_wb_fifo.sv | 70 +++++++
 rtl/fx_writeback_unit.sv | 191 +++++++++++++++++++
 tb/tb_fx_writeback_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// Shared FX-side definitions: unit codes, instruction formats and
// the writeback bundle type carried from the FX unit to writeback.
package fx_pkg;

    localparam logic [2:0] FX_UNIT_CODE   = 3'd0;
    localparam logic [2:0] FP_UNIT_CODE   = 3'd1;
    localparam logic [2:0] LS_UNIT_CODE   = 3'd2;
    localparam logic [2:0] BR_UNIT_CODE   = 3'd3;
    localparam logic [2:0] CR_UNIT_CODE   = 3'd4;
    localparam logic [2:0] SYS_UNIT_CODE  = 3'd5;
    localparam logic [2:0] TRAP_UNIT_CODE = 3'd6;

    typedef enum logic [3:0] {
        FMT_I,
        FMT_B,
        FMT_SC,
        FMT_D,
        FMT_DS,
        FMT_X,
        FMT_XL,
        FMT_XFX,
        FMT_XO,
        FMT_A,
        FMT_M,
        FMT_MD,
        FMT_MDS
    } insn_fmt_e;

    localparam int unsigned WB_REG_W = 5;

    typedef struct packed {
        logic [WB_REG_W-1:0] addr;
        logic [63:0]         val;
    } wb_entry_t;

endpackage

// File: rtl/fx_writeback_unit_wb_fifo.sv
// In-order sync FIFO with occupancy count and a flat view of every
// storage slot so the owner can scan pending entries by age.
module wb_fifo #(
    parameter int unsigned W     = 69,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [W-1:0]       i_data,
    output logic [W-1:0]       o_head,
    output logic               o_empty,
    output logic               o_push_ok,
    output logic               o_drop,
    output logic [CW-1:0]      o_count,
    output logic [CW-1:0]      o_count_next,
    output logic [PW-1:0]      o_rd_ptr,
    output logic [DEPTH*W-1:0] o_entries
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_pop_ok;

    assign o_empty      = (r_count == '0);
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_pop_ok     = i_pop && !o_empty;
    assign o_push_ok    = i_push && (!w_full || w_pop_ok);
    assign o_drop       = i_push && !o_push_ok;
    assign o_count_next = r_count + CW'(o_push_ok) - CW'(w_pop_ok);
    assign o_count      = r_count;
    assign o_rd_ptr     = r_rd_ptr;
    assign o_head       = r_mem[r_rd_ptr];

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_flat
        assign o_entries[g*W +: W] = r_mem[g];
    end

    // Storage write; contents need no reset since count gates validity.
    always_ff @(posedge i_clk) begin
        if (o_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and count bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (o_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= o_count_next;
        end
    end

endmodule

// File: rtl/fx_writeback_unit.sv
// FX writeback receiver: buffers GPR writes toward the register file,
// forwards pending values and owns the XER SO/OV/CA bits and CR0.
module fx_writeback_unit
    import fx_pkg::*;
#(
    parameter int unsigned regWidth   = 5,
    parameter int unsigned depth      = 4,
    parameter logic [2:0]  FXUnitCode = FX_UNIT_CODE,
    parameter int unsigned stallSlack = 2
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic [2:0]          functionalUnitCode_i,
    input  logic                wbEnable_i,
    input  logic [regWidth-1:0] wbAddress_i,
    input  logic [63:0]         wbVal_i,
    input  logic                crUpdate_i,
    input  logic [3:0]          CR0_i,
    input  logic                ovUpdate_i,
    input  logic                OV_i,
    input  logic                setSO_i,
    input  logic                caUpdate_i,
    input  logic                CA_i,
    input  logic                xerWrite_i,
    input  logic [2:0]          xerWriteVal_i,
    output logic                rfWriteEnable_o,
    output logic [regWidth-1:0] rfWriteAddress_o,
    output logic [63:0]         rfWriteVal_o,
    input  logic                rfReady_i,
    input  logic [regWidth-1:0] lookupAddr_i,
    output logic                lookupHit_o,
    output logic [63:0]         lookupVal_o,
    output logic                stall_o,
    output logic                overflow_o,
    output logic                SO_o,
    output logic                OV_o,
    output logic                CA_o,
    output logic [3:0]          CR0_o
);

    localparam int unsigned EW = regWidth + 64;
    localparam int unsigned PW = $clog2(depth);
    localparam int unsigned CW = PW + 1;

    logic w_accept;
    logic w_push_req;
    logic w_pop_req;
    logic w_push_ok;
    logic w_drop;
    logic w_empty;
    logic w_stall_next;
    logic w_unused_cr0;

    logic [EW-1:0]       w_wr_data;
    logic [EW-1:0]       w_head;
    logic [EW-1:0]       w_ent;
    logic [CW-1:0]       w_count;
    logic [CW-1:0]       w_count_next;
    logic [CW-1:0]       w_free;
    logic [PW-1:0]       w_rd_ptr;
    logic [PW-1:0]       w_idx;
    logic [depth*EW-1:0] w_entries;

    logic        w_hit;
    logic [63:0] w_hit_val;
    logic        w_so_next;
    logic        w_ov_next;
    logic        w_ca_next;
    logic [3:0]  w_cr0_next;

    logic       r_stall;
    logic       r_overflow;
    logic       r_so;
    logic       r_ov;
    logic       r_ca;
    logic [3:0] r_cr0;

    // Nothing is accepted while reset is held, so no write leaks out.
    assign w_accept   = reset_i &&
                        (functionalUnitCode_i == FXUnitCode);
    assign w_push_req = w_accept && wbEnable_i;
    assign w_wr_data  = {wbAddress_i, wbVal_i};
    assign w_pop_req  = rfWriteEnable_o && rfReady_i;

    wb_fifo #(
        .W     (EW),
        .DEPTH (depth)
    ) u_fifo (
        .i_clk        (clock_i),
        .i_rst_n      (reset_i),
        .i_push       (w_push_req),
        .i_pop        (w_pop_req),
        .i_data       (w_wr_data),
        .o_head       (w_head),
        .o_empty      (w_empty),
        .o_push_ok    (w_push_ok),
        .o_drop       (w_drop),
        .o_count      (w_count),
        .o_count_next (w_count_next),
        .o_rd_ptr     (w_rd_ptr),
        .o_entries    (w_entries)
    );

    assign rfWriteEnable_o  = reset_i && !w_empty;
    assign rfWriteAddress_o = rfWriteEnable_o ?
                              w_head[EW-1:64] : '0;
    assign rfWriteVal_o     = rfWriteEnable_o ?
                              w_head[63:0] : '0;

    assign w_free       = CW'(depth) - w_count_next;
    assign w_stall_next = 32'(w_free) <= 32'(stallSlack);

    // Forwarding scan oldest to youngest; the incoming push is youngest.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_val = '0;
        w_idx     = '0;
        w_ent     = '0;
        for (int k = 0; k < int'(depth); k++) begin
            w_idx = w_rd_ptr + PW'(k);
            w_ent = w_entries[32'(w_idx)*EW +: EW];
            if (reset_i && (CW'(k) < w_count) &&
                (w_ent[EW-1:64] == lookupAddr_i)) begin
                w_hit     = 1'b1;
                w_hit_val = w_ent[63:0];
            end
        end
        if (w_push_ok && (wbAddress_i == lookupAddr_i)) begin
            w_hit     = 1'b1;
            w_hit_val = wbVal_i;
        end
    end

    assign lookupHit_o = w_hit;
    assign lookupVal_o = w_hit_val;

    // Next XER/CR0: an explicit XER write overrides the FX strobes.
    always_comb begin
        w_so_next  = r_so;
        w_ov_next  = r_ov;
        w_ca_next  = r_ca;
        w_cr0_next = r_cr0;
        if (w_accept) begin
            if (xerWrite_i) begin
                w_so_next = xerWriteVal_i[2];
                w_ov_next = xerWriteVal_i[1];
                w_ca_next = xerWriteVal_i[0];
            end else begin
                if (ovUpdate_i) begin
                    w_ov_next = OV_i;
                end
                if (caUpdate_i) begin
                    w_ca_next = CA_i;
                end
                w_so_next = r_so | setSO_i | (ovUpdate_i & OV_i);
            end
            if (crUpdate_i) begin
                w_cr0_next = {CR0_i[3:1], w_so_next};
            end
        end
    end

    assign w_unused_cr0 = CR0_i[0];

    // Registered status: stall, sticky overflow, XER bits and CR0.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
            r_so       <= 1'b0;
            r_ov       <= 1'b0;
            r_ca       <= 1'b0;
            r_cr0      <= 4'b0;
        end else begin
            r_stall    <= w_stall_next;
            r_overflow <= r_overflow | w_drop;
            r_so       <= w_so_next;
            r_ov       <= w_ov_next;
            r_ca       <= w_ca_next;
            r_cr0      <= w_cr0_next;
        end
    end

    assign stall_o    = r_stall;
    assign overflow_o = r_overflow;
    assign SO_o       = r_so;
    assign OV_o       = r_ov;
    assign CA_o       = r_ca;
    assign CR0_o      = r_cr0;

endmodule

// File: tb/tb_fx_writeback_unit.sv
// Bench for fx_writeback_unit: queue-based reference model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_fx_writeback_unit;
    import fx_pkg::*;

    localparam int DEPTH = 4;
    localparam int SLACK = 2;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [2:0]  fu;
    logic        wbEnable;
    logic [4:0]  wbAddress;
    logic [63:0] wbVal;
    logic        crUpdate;
    logic [3:0]  CR0_i;
    logic        ovUpdate;
    logic        OV_i;
    logic        setSO;
    logic        caUpdate;
    logic        CA_i;
    logic        xerWrite;
    logic [2:0]  xerWriteVal;
    logic        rfReady;
    logic [4:0]  lookupAddr;

    logic        rfWE;
    logic [4:0]  rfAddr;
    logic [63:0] rfVal;
    logic        hit;
    logic [63:0] hitVal;
    logic        stall;
    logic        ovf;
    logic        SO_o;
    logic        OV_o;
    logic        CA_o;
    logic [3:0]  CR0_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    wb_entry_t   q[$];
    wb_entry_t   m_e;
    bit          m_ovf, m_stall, m_so, m_ov, m_ca;
    logic [3:0]  m_cr0;
    bit          e_hit, e_push;
    logic [63:0] e_val;

    fx_writeback_unit dut (
        .clock_i              (clk),
        .reset_i              (reset_i),
        .functionalUnitCode_i (fu),
        .wbEnable_i           (wbEnable),
        .wbAddress_i          (wbAddress),
        .wbVal_i              (wbVal),
        .crUpdate_i           (crUpdate),
        .CR0_i                (CR0_i),
        .ovUpdate_i           (ovUpdate),
        .OV_i                 (OV_i),
        .setSO_i              (setSO),
        .caUpdate_i           (caUpdate),
        .CA_i                 (CA_i),
        .xerWrite_i           (xerWrite),
        .xerWriteVal_i        (xerWriteVal),
        .rfWriteEnable_o      (rfWE),
        .rfWriteAddress_o     (rfAddr),
        .rfWriteVal_o         (rfVal),
        .rfReady_i            (rfReady),
        .lookupAddr_i         (lookupAddr),
        .lookupHit_o          (hit),
        .lookupVal_o          (hitVal),
        .stall_o              (stall),
        .overflow_o           (ovf),
        .SO_o                 (SO_o),
        .OV_o                 (OV_o),
        .CA_o                 (CA_o),
        .CR0_o                (CR0_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want,
                     $time);
        end
    endtask

    // Reference model: architectural state advanced at each clock edge.
    always @(posedge clk) begin
        if (!reset_i) begin
            q.delete();
            m_ovf = 0; m_stall = 0;
            m_so = 0; m_ov = 0; m_ca = 0; m_cr0 = 4'b0;
        end else if (fu == 3'd0) begin
            if (q.size() > 0 && rfReady) q.delete(0);
            if (wbEnable) begin
                if (q.size() < DEPTH) begin
                    m_e.addr = wbAddress;
                    m_e.val  = wbVal;
                    q.push_back(m_e);
                end else begin
                    m_ovf = 1;
                end
            end
            m_stall = (DEPTH - q.size()) <= SLACK;
            if (xerWrite) begin
                {m_so, m_ov, m_ca} = xerWriteVal;
            end else begin
                if (ovUpdate) m_ov = OV_i;
                if (caUpdate) m_ca = CA_i;
                if (setSO || (ovUpdate && OV_i)) m_so = 1;
            end
            if (crUpdate) m_cr0 = {CR0_i[3:1], m_so};
        end else begin
            if (q.size() > 0 && rfReady) q.delete(0);
            m_stall = (DEPTH - q.size()) <= SLACK;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en && reset_i) begin
            e_push = (fu == 3'd0) && wbEnable &&
                     (q.size() < DEPTH || (q.size() > 0 && rfReady));
            e_hit = 0;
            e_val = '0;
            foreach (q[i]) begin
                if (q[i].addr == lookupAddr) begin
                    e_hit = 1;
                    e_val = q[i].val;
                end
            end
            if (e_push && wbAddress == lookupAddr) begin
                e_hit = 1;
                e_val = wbVal;
            end
            chk("m_rfWE", 64'(rfWE), 64'(q.size() > 0));
            chk("m_rfAddr", 64'(rfAddr),
                q.size() > 0 ? 64'(q[0].addr) : 64'd0);
            chk("m_rfVal", rfVal, q.size() > 0 ? q[0].val : 64'd0);
            chk("m_hit", 64'(hit), 64'(e_hit));
            chk("m_hitVal", hitVal, e_val);
            chk("m_stall", 64'(stall), 64'(m_stall));
            chk("m_ovf", 64'(ovf), 64'(m_ovf));
            chk("m_xer", 64'({SO_o, OV_o, CA_o}),
                64'({m_so, m_ov, m_ca}));
            chk("m_cr0", 64'(CR0_o), 64'(m_cr0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fu = 3'd0; wbEnable = 0; wbAddress = '0; wbVal = '0;
        crUpdate = 0; CR0_i = '0; ovUpdate = 0; OV_i = 0;
        setSO = 0; caUpdate = 0; CA_i = 0; xerWrite = 0;
        xerWriteVal = '0;
    endtask

    task automatic push(input logic [4:0] a, input logic [63:0] v);
        wbEnable = 1; wbAddress = a; wbVal = v;
        step();
        wbEnable = 0;
        #1;
    endtask

    initial begin
        idle();
        rfReady = 0; lookupAddr = '0; reset_i = 0;
        step(); step();
        reset_i = 1;
        chk_en = 1;
        #1;
        chk("rst_rfWE", 64'(rfWE), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_cr0", 64'(CR0_o), 64'd0);

        // single write, 1-cycle latency, then popped
        rfReady = 1;
        push(5'd3, 64'h1234);
        chk("t1_we", 64'(rfWE), 64'd1);
        chk("t1_addr", 64'(rfAddr), 64'd3);
        chk("t1_val", rfVal, 64'h1234);
        step();
        chk("t1_we_off", 64'(rfWE), 64'd0);

        // fill, stall after 2nd, overflow on 5th
        rfReady = 0;
        for (int k = 1; k <= 4; k++) begin
            push(5'(k), 64'h100 + 64'(k));
            if (k == 1) chk("t2_stall1", 64'(stall), 64'd0);
            if (k == 2) chk("t2_stall2", 64'(stall), 64'd1);
        end
        chk("t2_ovf_pre", 64'(ovf), 64'd0);
        push(5'd5, 64'h105);
        chk("t2_ovf", 64'(ovf), 64'd1);
        rfReady = 1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("t2_drain_addr", 64'(rfAddr), 64'(k));
            chk("t2_drain_val", rfVal, 64'h100 + 64'(k));
            step();
        end
        chk("t2_empty", 64'(rfWE), 64'd0);
        chk("t2_stall0", 64'(stall), 64'd0);

        // forwarding: youngest match wins, same-cycle push forwards
        rfReady = 0;
        push(5'd7, 64'hA);
        push(5'd7, 64'hB);
        lookupAddr = 5'd7;
        #1;
        chk("t3_hit", 64'(hit), 64'd1);
        chk("t3_val", hitVal, 64'hB);
        wbEnable = 1; wbAddress = 5'd7; wbVal = 64'hC;
        #1;
        chk("t3_fwd_val", hitVal, 64'hC);
        wbEnable = 0;
        lookupAddr = 5'd8;
        #1;
        chk("t3_miss", 64'(hit), 64'd0);
        chk("t3_miss_val", hitVal, 64'd0);
        rfReady = 1;
        step(); step();

        // XER / CR0
        ovUpdate = 1; OV_i = 1;
        step();
        ovUpdate = 0; OV_i = 0;
        #1;
        chk("t4_ov1", 64'(OV_o), 64'd1);
        chk("t4_so1", 64'(SO_o), 64'd1);
        ovUpdate = 1; OV_i = 0;
        step();
        ovUpdate = 0;
        #1;
        chk("t4_ov0", 64'(OV_o), 64'd0);
        chk("t4_so_sticky", 64'(SO_o), 64'd1);
        crUpdate = 1; CR0_i = 4'b1000; caUpdate = 1; CA_i = 1;
        step();
        idle();
        #1;
        chk("t4_cr0", 64'(CR0_o), 64'b1001);
        chk("t4_ca", 64'(CA_o), 64'd1);

        // xerWrite beats setSO; foreign unit ignored
        xerWrite = 1; xerWriteVal = 3'b000; setSO = 1;
        step();
        idle();
        #1;
        chk("t5_so", 64'(SO_o), 64'd0);
        chk("t5_ca", 64'(CA_o), 64'd0);
        fu = 3'd2; wbEnable = 1; wbAddress = 5'd9; wbVal = 64'h9;
        ovUpdate = 1; OV_i = 1;
        step();
        idle();
        #1;
        chk("t5_nopush", 64'(rfWE), 64'd0);
        chk("t5_no_ov", 64'(OV_o), 64'd0);

        // reset with pending entries; address 0 forwards
        rfReady = 0; lookupAddr = 5'd0;
        push(5'd0, 64'hAAA);
        push(5'd20, 64'hBBB);
        push(5'd21, 64'hCCC);
        chk("t6_hit0", 64'(hit), 64'd1);
        chk("t6_val0", hitVal, 64'hAAA);
        rfReady = 1;
        reset_i = 0;
        step();
        reset_i = 1;
        #1;
        chk("t6_we", 64'(rfWE), 64'd0);
        chk("t6_addr", 64'(rfAddr), 64'd0);
        chk("t6_val", rfVal, 64'd0);
        chk("t6_hit", 64'(hit), 64'd0);
        chk("t6_ovf", 64'(ovf), 64'd0);
        chk("t6_cr0", 64'(CR0_o), 64'd0);
        step();
        chk("t6_still_empty", 64'(rfWE), 64'd0);

        // push with pop while full: no overflow, order kept
        rfReady = 0;
        for (int k = 1; k <= 4; k++) push(5'(k), 64'h200 + 64'(k));
        rfReady = 1;
        push(5'd9, 64'h999);
        chk("t7_ovf", 64'(ovf), 64'd0);
        chk("t7_head", 64'(rfAddr), 64'd2);
        chk("t7_stall", 64'(stall), 64'd1);
        for (int k = 0; k < 5; k++) step();
        chk("t7_empty", 64'(rfWE), 64'd0);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
